// File: rtl/class_hvec_pkg.sv
// Shared types and index-width helper for the class-hypervector store.
// Imported by the storage array and the streaming top level.
package class_hvec_pkg;

  // Index width for a count of n items; never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_e;

  typedef struct packed {
    logic last_frame;
    logic last;
  } beat_flags_t;

endpackage

// File: rtl/class_hvec_regfile.sv
// Frame storage for all class vectors: one write port, one registered read port.
// The read register only loads on rd_en, so a presented beat holds its captured data.
module class_hvec_regfile #(
  parameter int W      = 64,
  parameter int DEPTH  = 24,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [W-1:0]      wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [W-1:0]      rd_data
);

  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] rd_data_q;
  logic [W-1:0] rd_data_d;

  // Read samples the array before this edge's write lands (read-before-write).
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) begin
      rd_data_d = mem_q[rd_addr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_data_q <= '0;
    end else begin
      if (wr_en) begin
        mem_q[wr_addr] <= wr_data;
      end
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/class_hvec_store.sv
// Writable class-hypervector store: streams one class or all classes frame by frame
// over valid/ready, while accepting frame writes from the training/load path.
module class_hvec_store
  import class_hvec_pkg::*;
#(
  parameter int DI_PARALLEL_W_BITS = 64,
  parameter int NUM_CLASSES        = 8,
  parameter int FRAMES_PER_CLASS   = 3
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 wr_en,
  input  logic [idx_w(NUM_CLASSES)-1:0]        wr_class,
  input  logic [idx_w(FRAMES_PER_CLASS)-1:0]   wr_frame,
  input  logic [DI_PARALLEL_W_BITS-1:0]        wr_data,
  input  logic                                 req_valid,
  output logic                                 req_ready,
  input  logic                                 req_sweep,
  input  logic [idx_w(NUM_CLASSES)-1:0]        req_class,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [DI_PARALLEL_W_BITS-1:0]        out_data,
  output logic [idx_w(NUM_CLASSES)-1:0]        out_class,
  output logic [idx_w(FRAMES_PER_CLASS)-1:0]   out_frame,
  output logic                                 out_last_frame,
  output logic                                 out_last,
  output logic                                 req_err
);

  localparam int CLASS_W = idx_w(NUM_CLASSES);
  localparam int FRAME_W = idx_w(FRAMES_PER_CLASS);
  localparam int DEPTH   = NUM_CLASSES * FRAMES_PER_CLASS;
  localparam int ADDR_W  = idx_w(DEPTH);
  localparam logic [CLASS_W-1:0] LAST_CLASS = CLASS_W'(NUM_CLASSES - 1);
  localparam logic [FRAME_W-1:0] LAST_FRAME = FRAME_W'(FRAMES_PER_CLASS - 1);

  // Tag of the beat on the output; its data lives in the regfile read register.
  typedef struct packed {
    logic [CLASS_W-1:0] cls;
    logic [FRAME_W-1:0] frame;
    beat_flags_t        flags;
  } beat_t;

  function automatic logic [ADDR_W-1:0] addr_of(input logic [CLASS_W-1:0] c,
                                                input logic [FRAME_W-1:0] f);
    return ADDR_W'(int'(c) * FRAMES_PER_CLASS + int'(f));
  endfunction

  state_e state_q, state_d;
  beat_t  beat_q, beat_d;
  logic   valid_q, valid_d;
  logic   sweep_q, sweep_d;
  logic   req_err_q, req_err_d;
  logic   fetch;
  logic   wr_ok;
  logic [DI_PARALLEL_W_BITS-1:0] rd_data;

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    valid_d   = valid_q;
    sweep_d   = sweep_q;
    req_err_d = 1'b0;
    fetch     = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (req_sweep || (int'(req_class) < NUM_CLASSES)) begin
            state_d      = STREAM;
            sweep_d      = req_sweep;
            beat_d.cls   = req_sweep ? '0 : req_class;
            beat_d.frame = '0;
            fetch        = 1'b1;
          end else begin
            req_err_d = 1'b1;
          end
        end
      end
      STREAM: begin
        if (valid_q && out_ready) begin
          if (beat_q.flags.last) begin
            state_d = IDLE;
            valid_d = 1'b0;
          end else begin
            fetch = 1'b1;
            if (beat_q.frame == LAST_FRAME) begin
              beat_d.frame = '0;
              beat_d.cls   = beat_q.cls + CLASS_W'(1);
            end else begin
              beat_d.frame = beat_q.frame + FRAME_W'(1);
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (fetch) begin
      valid_d                 = 1'b1;
      beat_d.flags.last_frame = (beat_d.frame == LAST_FRAME);
      beat_d.flags.last       = beat_d.flags.last_frame &&
                                (!sweep_d || (beat_d.cls == LAST_CLASS));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      beat_q    <= '0;
      valid_q   <= 1'b0;
      sweep_q   <= 1'b0;
      req_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      valid_q   <= valid_d;
      sweep_q   <= sweep_d;
      req_err_q <= req_err_d;
    end
  end

  // Out-of-range coordinates would alias into a neighbouring class, so drop them.
  assign wr_ok = wr_en && (int'(wr_class) < NUM_CLASSES) &&
                 (int'(wr_frame) < FRAMES_PER_CLASS);

  class_hvec_regfile #(
    .W     (DI_PARALLEL_W_BITS),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_regfile (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_en  (wr_ok),
    .wr_addr(addr_of(wr_class, wr_frame)),
    .wr_data(wr_data),
    .rd_en  (fetch),
    .rd_addr(addr_of(beat_d.cls, beat_d.frame)),
    .rd_data(rd_data)
  );

  assign req_ready      = (state_q == IDLE);
  assign req_err        = req_err_q;
  assign out_valid      = valid_q;
  assign out_data       = rd_data;
  assign out_class      = beat_q.cls;
  assign out_frame      = beat_q.frame;
  assign out_last_frame = beat_q.flags.last_frame;
  assign out_last       = beat_q.flags.last;

endmodule

// File: tb/tb_class_hvec_store.sv
// Bench for class_hvec_store: default instance (8x3 frames) and a 5x1 instance,
// scoreboard queues filled from a bench-side storage model, checked on each output beat.
module tb_class_hvec_store;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Default instance
  logic        a_wr_en = 1'b0;
  logic [2:0]  a_wr_class = '0;
  logic [1:0]  a_wr_frame = '0;
  logic [63:0] a_wr_data = '0;
  logic        a_req_valid = 1'b0, a_req_sweep = 1'b0;
  logic [2:0]  a_req_class = '0;
  logic        a_req_ready, a_out_valid, a_out_last_frame, a_out_last, a_req_err;
  logic        a_out_ready = 1'b1;
  logic [63:0] a_out_data;
  logic [2:0]  a_out_class;
  logic [1:0]  a_out_frame;

  // 5 classes x 1 frame instance
  logic        b_wr_en = 1'b0;
  logic [2:0]  b_wr_class = '0;
  logic [0:0]  b_wr_frame = '0;
  logic [15:0] b_wr_data = '0;
  logic        b_req_valid = 1'b0, b_req_sweep = 1'b0;
  logic [2:0]  b_req_class = '0;
  logic        b_req_ready, b_out_valid, b_out_last_frame, b_out_last, b_req_err;
  logic        b_out_ready = 1'b1;
  logic [15:0] b_out_data;
  logic [2:0]  b_out_class;
  logic [0:0]  b_out_frame;

  class_hvec_store u_a (
    .clk(clk), .rst_n(rst_n),
    .wr_en(a_wr_en), .wr_class(a_wr_class), .wr_frame(a_wr_frame), .wr_data(a_wr_data),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_sweep(a_req_sweep),
    .req_class(a_req_class), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_data(a_out_data), .out_class(a_out_class), .out_frame(a_out_frame),
    .out_last_frame(a_out_last_frame), .out_last(a_out_last), .req_err(a_req_err)
  );

  class_hvec_store #(
    .DI_PARALLEL_W_BITS(16), .NUM_CLASSES(5), .FRAMES_PER_CLASS(1)
  ) u_b (
    .clk(clk), .rst_n(rst_n),
    .wr_en(b_wr_en), .wr_class(b_wr_class), .wr_frame(b_wr_frame), .wr_data(b_wr_data),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_sweep(b_req_sweep),
    .req_class(b_req_class), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data), .out_class(b_out_class), .out_frame(b_out_frame),
    .out_last_frame(b_out_last_frame), .out_last(b_out_last), .req_err(b_req_err)
  );

  typedef struct {
    logic [63:0] data;
    logic [2:0]  cls;
    logic [1:0]  frm;
    logic        lf;
    logic        l;
  } beat_t;

  typedef struct {
    logic       sweep;
    logic [2:0] cls;
    int         rmode;
    int         exp_beats;
  } vec_t;

  beat_t       qa[$], qb[$];
  logic [63:0] model_a [8][3];
  logic [63:0] model_b [5];
  int          n_checks = 0, n_pass = 0;
  int          a_beats = 0, b_beats = 0;
  int          ready_mode = 0;
  logic        a_exp_idle = 1'b0, b_exp_idle = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // out_ready driver: 0 always 1, 1 pattern 1,0,0,1, 2 random, 3 held low
  initial begin
    int k;
    k = 0;
    forever begin
      @(posedge clk); #1;
      k++;
      case (ready_mode)
        0: a_out_ready = 1'b1;
        1: a_out_ready = ((k % 4) == 0) || ((k % 4) == 3);
        2: a_out_ready = 1'($urandom_range(0, 1));
        default: a_out_ready = 1'b0;
      endcase
    end
  end

  always @(negedge clk) begin
    beat_t ea;
    if (!rst_n) a_exp_idle = 1'b0;
    else begin
      if (a_exp_idle) begin
        check("a_idle_ready", 64'(a_req_ready), 64'(1));
        check("a_idle_valid", 64'(a_out_valid), 64'(0));
        a_exp_idle = 1'b0;
      end
      if (a_out_valid) begin
        if (qa.size() == 0) begin
          n_checks++;
          $display("FAIL a_unexpected_beat: class %0d frame %0d, expected no beat", a_out_class, a_out_frame);
        end else begin
          ea = qa[0];
          check("a_beat_data", a_out_data, ea.data);
          check("a_beat_tag", 64'({a_out_class, a_out_frame, a_out_last_frame, a_out_last}),
                64'({ea.cls, ea.frm, ea.lf, ea.l}));
          if (a_out_ready) begin
            ea = qa.pop_front();
            a_beats++;
            a_exp_idle = ea.l;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    beat_t eb;
    if (!rst_n) b_exp_idle = 1'b0;
    else begin
      if (b_exp_idle) begin
        check("b_idle_ready", 64'(b_req_ready), 64'(1));
        check("b_idle_valid", 64'(b_out_valid), 64'(0));
        b_exp_idle = 1'b0;
      end
      if (b_out_valid) begin
        if (qb.size() == 0) begin
          n_checks++;
          $display("FAIL b_unexpected_beat: class %0d, expected no beat", b_out_class);
        end else begin
          eb = qb[0];
          check("b_beat_data", 64'(b_out_data), eb.data);
          check("b_beat_tag", 64'({b_out_class, b_out_frame, b_out_last_frame, b_out_last}),
                64'({eb.cls, eb.frm[0], eb.lf, eb.l}));
          if (b_out_ready) begin
            eb = qb.pop_front();
            b_beats++;
            b_exp_idle = eb.l;
          end
        end
      end
    end
  end

  function automatic void push_a(input logic sweep, input int cls);
    int c0, c1;
    c0 = sweep ? 0 : cls;
    c1 = sweep ? 7 : cls;
    for (int c = c0; c <= c1; c++) begin
      for (int f = 0; f < 3; f++) begin
        beat_t e;
        e.data = model_a[c][f];
        e.cls  = 3'(c);
        e.frm  = 2'(f);
        e.lf   = (f == 2);
        e.l    = (f == 2) && (c == c1);
        qa.push_back(e);
      end
    end
  endfunction

  function automatic void push_b(input logic sweep, input int cls);
    int c0, c1;
    c0 = sweep ? 0 : cls;
    c1 = sweep ? 4 : cls;
    for (int c = c0; c <= c1; c++) begin
      beat_t e;
      e.data = model_b[c];
      e.cls  = 3'(c);
      e.frm  = 2'd0;
      e.lf   = 1'b1;
      e.l    = (c == c1);
      qb.push_back(e);
    end
  endfunction

  task automatic wr_a(input int c, input int f, input logic [63:0] d);
    @(posedge clk); #1;
    a_wr_en = 1'b1; a_wr_class = 3'(c); a_wr_frame = 2'(f); a_wr_data = d;
    @(posedge clk); #1;
    a_wr_en = 1'b0;
    if (c < 8 && f < 3) model_a[c][f] = d;
  endtask

  task automatic wr_b(input int c, input int f, input logic [15:0] d);
    @(posedge clk); #1;
    b_wr_en = 1'b1; b_wr_class = 3'(c); b_wr_frame = 1'(f); b_wr_data = d;
    @(posedge clk); #1;
    b_wr_en = 1'b0;
    if (c < 5 && f < 1) model_b[c] = 64'(d);
  endtask

  // Drive a request; the beat after the accepting edge must already be frame 0.
  task automatic req_a(input logic sweep, input logic [2:0] cls);
    @(posedge clk); #1;
    a_req_valid = 1'b1; a_req_sweep = sweep; a_req_class = cls;
    @(posedge clk); #1;
    a_req_valid = 1'b0;
    check("a_first_valid", 64'(a_out_valid), 64'(1));
    check("a_first_frame", 64'(a_out_frame), 64'(0));
  endtask

  task automatic req_b(input logic sweep, input logic [2:0] cls);
    @(posedge clk); #1;
    b_req_valid = 1'b1; b_req_sweep = sweep; b_req_class = cls;
    @(posedge clk); #1;
    b_req_valid = 1'b0;
  endtask

  task automatic wait_done_a(input string name);
    int n;
    n = 0;
    while (!(qa.size() == 0 && a_req_ready && !a_out_valid) && n < 400) begin
      @(negedge clk); n++;
    end
    n_checks++;
    if (n >= 400) $display("FAIL %s: timeout with %0d beats outstanding", name, qa.size());
    else n_pass++;
  endtask

  task automatic wait_done_b(input string name);
    int n;
    n = 0;
    while (!(qb.size() == 0 && b_req_ready && !b_out_valid) && n < 100) begin
      @(negedge clk); n++;
    end
    n_checks++;
    if (n >= 100) $display("FAIL %s: timeout with %0d beats outstanding", name, qb.size());
    else n_pass++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[5];
    int   start;
    tbl[0] = '{1'b0, 3'd2, 0, 3};
    tbl[1] = '{1'b1, 3'd0, 0, 24};
    tbl[2] = '{1'b1, 3'd0, 1, 24};
    tbl[3] = '{1'b0, 3'd7, 2, 3};
    tbl[4] = '{1'b1, 3'd5, 2, 24};
    for (int c = 0; c < 8; c++) for (int f = 0; f < 3; f++) model_a[c][f] = '0;
    for (int c = 0; c < 5; c++) model_b[c] = '0;

    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    check("rst_a_req_ready", 64'(a_req_ready), 64'(1));
    check("rst_a_out_valid", 64'(a_out_valid), 64'(0));
    check("rst_a_out_data", a_out_data, 64'(0));
    check("rst_a_flags", 64'({a_out_last_frame, a_out_last, a_req_err}), 64'(0));
    check("rst_b_req_ready", 64'(b_req_ready), 64'(1));
    check("rst_b_out_valid", 64'(b_out_valid), 64'(0));

    for (int c = 0; c < 8; c++)
      for (int f = 0; f < 3; f++)
        wr_a(c, f, {$urandom, $urandom});
    wr_a(2, 0, 64'hA0);
    wr_a(2, 1, 64'hA1);
    wr_a(2, 2, 64'hA2);
    wr_a(1, 3, 64'hDEAD);  // frame out of range: must not alias into class 2

    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      ready_mode = tbl[i].rmode;
      start = a_beats;
      push_a(tbl[i].sweep, int'(tbl[i].cls));
      req_a(tbl[i].sweep, tbl[i].cls);
      wait_done_a("a_vec_done");
      check("a_vec_beats", 64'(a_beats - start), 64'(tbl[i].exp_beats));
      $display("vector %0d: sweep=%0d class=%0d beats=%0d", i, tbl[i].sweep, tbl[i].cls, a_beats - start);
    end

    // Writes while class 3 frame 0 is stalled, then a write colliding with the frame 1 fetch.
    @(negedge clk);
    ready_mode = 3;
    push_a(1'b0, 3);
    qa[1].data = 64'hFF;
    req_a(1'b0, 3'd3);
    wr_a(3, 1, 64'hFF);
    wr_a(3, 0, 64'hEE);
    @(negedge clk);
    ready_mode = 0;
    @(posedge clk); #1;
    a_wr_en = 1'b1; a_wr_class = 3'd3; a_wr_frame = 2'd1; a_wr_data = 64'h11;
    @(posedge clk); #1;
    a_wr_en = 1'b0;
    model_a[3][1] = 64'h11;
    wait_done_a("a_collision_done");
    $display("collision: stalled beat held, colliding fetch read old data");
    push_a(1'b0, 3);
    req_a(1'b0, 3'd3);
    wait_done_a("a_collision_readback");
    $display("collision readback: class 3 frames EE, 11, unchanged");

    // Reset in the middle of a sweep.
    @(negedge clk);
    push_a(1'b1, 0);
    req_a(1'b1, 3'd0);
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 64'(a_out_valid), 64'(0));
    check("midrst_out_data", a_out_data, 64'(0));
    check("midrst_out_flags", 64'({a_out_last_frame, a_out_last}), 64'(0));
    qa.delete();
    for (int c = 0; c < 8; c++) for (int f = 0; f < 3; f++) model_a[c][f] = '0;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    check("midrst_req_ready", 64'(a_req_ready), 64'(1));
    start = a_beats;
    push_a(1'b1, 0);
    req_a(1'b1, 3'd0);
    wait_done_a("a_zero_sweep");
    check("a_zero_sweep_beats", 64'(a_beats - start), 64'(24));
    $display("reset mid-sweep: storage reads back zero");

    // 5 classes x 1 frame instance.
    for (int c = 0; c < 5; c++) wr_b(c, 0, 16'(16'hB0 + c));
    wr_b(0, 1, 16'hDEAD);  // frame out of range: must not alias into class 1
    wr_b(6, 0, 16'hBEEF);  // class out of range
    @(negedge clk);
    start = b_beats;
    push_b(1'b1, 0);
    req_b(1'b1, 3'd6);
    wait_done_b("b_sweep_done");
    check("b_sweep_beats", 64'(b_beats - start), 64'(5));
    $display("b sweep: %0d beats", b_beats - start);
    push_b(1'b0, 2);
    req_b(1'b0, 3'd2);
    wait_done_b("b_single_done");

    @(negedge clk);
    req_b(1'b0, 3'd6);
    check("b_req_err_pulse", 64'(b_req_err), 64'(1));
    check("b_err_no_valid", 64'(b_out_valid), 64'(0));
    @(posedge clk); #1;
    check("b_req_err_clear", 64'(b_req_err), 64'(0));
    check("b_err_still_idle", 64'({b_req_ready, b_out_valid}), 64'(2));
    $display("b error request: class 6 rejected");

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
